alu_beta_arbiter: RTL

Round-robin arbiter that shares one slave ALU (`alu_beta`) between two issue requesters with valid/ready handshakes. Each accepted operation passes through the combinational slave ALU. Its result, overflow flag and requester ID are written into a small response FIFO, so consumer backpressure never blocks the combinational path. The block sits between the dual-issue stage and the slave-pipe writeback. It also supports a flush for exception and branch-mispredict recovery.

---
 rtl/alu_beta_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_beta_arbiter.sv
// alu_beta_arbiter: two-requester round-robin front end for the slave ALU.
// Results are buffered in a small response FIFO with flush support.

package alu_beta_pkg;
  localparam logic [5:0] ALU_SLL  = 6'h00;
  localparam logic [5:0] ALU_SRL  = 6'h02;
  localparam logic [5:0] ALU_SRA  = 6'h03;
  localparam logic [5:0] ALU_LUI  = 6'h0F;
  localparam logic [5:0] ALU_ADD  = 6'h20;
  localparam logic [5:0] ALU_ADDU = 6'h21;
  localparam logic [5:0] ALU_SUB  = 6'h22;
  localparam logic [5:0] ALU_SUBU = 6'h23;
  localparam logic [5:0] ALU_AND  = 6'h24;
  localparam logic [5:0] ALU_OR   = 6'h25;
  localparam logic [5:0] ALU_XOR  = 6'h26;
  localparam logic [5:0] ALU_NOR  = 6'h27;
  localparam logic [5:0] ALU_SLT  = 6'h2A;
  localparam logic [5:0] ALU_SLTU = 6'h2B;
endpackage

module alu_beta
  import alu_beta_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        ovf_o
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  sh;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
  assign sh   = a_i[4:0];

  // Operation decode; only signed add/sub report overflow.
  always_comb begin
    result_o = '0;
    ovf_o    = 1'b0;
    case (op_i)
      ALU_ADD: begin
        result_o = sum;
        ovf_o    = (a_i[31] ~^ b_i[31]) & (sum[31] ^ a_i[31]);
      end
      ALU_ADDU: result_o = sum;
      ALU_SUB: begin
        result_o = diff;
        ovf_o    = (a_i[31] ^ b_i[31]) & (diff[31] ^ a_i[31]);
      end
      ALU_SUBU: result_o = diff;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'b0, a_i < b_i};
      ALU_SLL:  result_o = b_i << sh;
      ALU_SRL:  result_o = b_i >> sh;
      ALU_SRA:  result_o = 32'($signed(b_i) >>> sh);
      ALU_LUI:  result_o = {b_i[15:0], 16'h0000};
      default: begin
        result_o = '0;
        ovf_o    = 1'b0;
      end
    endcase
  end

endmodule

module alu_beta_arbiter
  import alu_beta_pkg::*;
#(
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][5:0]  req_op,
  input  logic [1:0][31:0] req_src_a,
  input  logic [1:0][31:0] req_src_b,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_id
);

  localparam int unsigned PW =
    (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);

  logic          prio_q, prio_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]          res_q [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] ovf_q;
  logic [RSP_DEPTH-1:0] id_q;

  logic        cand;
  logic        any_v;
  logic        pop;
  logic        push;
  logic        space;
  logic [5:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_ovf;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign any_v = |req_valid;
  assign pop   = rsp_valid & rsp_ready;
  assign space = (cnt_q < DEPTH_C) | pop;
  assign push  = |req_ready;

  // Candidate: a lone requester wins, otherwise the priority holder.
  always_comb begin
    cand = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): cand = prio_q;
      (req_valid == 2'b10): cand = 1'b1;
      default:              cand = 1'b0;
    endcase
  end

  // Grant only when there is room and no flush or reset.
  always_comb begin
    req_ready = '0;
    if (any_v & space & ~flush & ~rst) begin
      req_ready[cand] = 1'b1;
    end
  end

  // Single ALU shared through the candidate mux.
  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (any_v) begin
      alu_op = req_op[cand];
      alu_a  = req_src_a[cand];
      alu_b  = req_src_b[cand];
    end
  end

  alu_beta u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .ovf_o    (alu_ovf)
  );

  // Next-state for priority, pointers and occupancy.
  always_comb begin
    prio_d = prio_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        wptr_d = inc(wptr_q);
        prio_d = ~cand;
      end
      if (pop) begin
        rptr_d = inc(rptr_q);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Response storage written at the tail on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        res_q[i] <= '0;
      end
      ovf_q <= '0;
      id_q  <= '0;
    end else if (push) begin
      res_q[wptr_q] <= alu_res;
      ovf_q[wptr_q] <= alu_ovf;
      id_q[wptr_q]  <= cand;
    end
  end

  assign rsp_valid    = (cnt_q != '0);
  assign rsp_result   = res_q[rptr_q];
  assign rsp_overflow = ovf_q[rptr_q];
  assign rsp_id       = id_q[rptr_q];

endmodule
